axi_read_responder: RTL

Single-outstanding AXI4 read-channel responder that serves the instruction-fetch master's AR/R traffic from an internal 64-bit-wide word memory. It sits at the far end of the core's `m_axi_ar*`/`m_axi_r*` ports: in the bench it stands in for the Sysbus memory, and in-design it can serve as a boot ROM. It supports FIXED, INCR and WRAP bursts, narrow sizes, error responses and full R-channel backpressure. A side-band load port lets the memory be preloaded without using AXI.

---
 rtl/axi_read_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI4 read responder backed by a 64-bit word memory.
// Supports FIXED/INCR/WRAP bursts, narrow sizes, SLVERR/DECERR and a side-band preload port.
module axi_read_responder #(
   parameter int                    ID_WIDTH   = 13,
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    MEM_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   localparam int                   IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   input  logic                  load_we,
   input  logic [IDX_W-1:0]      load_idx,
   input  logic [DATA_WIDTH-1:0] load_data
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  legal_q;
   logic [7:0]            beat_cnt;

   logic                  ar_hs, r_hs, ar_legal;
   logic [ADDR_WIDTH-1:0] ar_step, step, wrap_mask, next_addr;
   logic [ADDR_WIDTH-1:0] cap_addr, cap_off;
   logic                  cap_legal;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [1:0]            cap_resp;

   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign r_hs  = s_axi_rvalid && s_axi_rready;

   // Legality is decided once per burst from the raw AR fields.
   always_comb begin
      ar_step  = ADDR_WIDTH'(1) << s_axi_arsize;
      ar_legal = (s_axi_arsize <= 3'd3) && (s_axi_arburst != 2'b11);
      if (s_axi_arburst == 2'b10)
         ar_legal = ar_legal && (s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})
                    && ((s_axi_araddr & (ar_step - 1'b1)) == '0);
   end

   // Wrap bound is a power of two for legal WRAP bursts, so OR-ing the
   // wrapped offset into the aligned base equals low + offset.
   always_comb begin
      step      = ADDR_WIDTH'(1) << size_q;
      wrap_mask = ((ADDR_WIDTH'(len_q) + 1'b1) << size_q) - 1'b1;
      case (burst_q)
         2'b00:   next_addr = addr_q;
         2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
         default: next_addr = addr_q + step;
      endcase
   end

   // Beat capture source: AR fields at accept, advanced address afterwards.
   always_comb begin
      cap_addr  = (state == IDLE) ? s_axi_araddr : next_addr;
      cap_legal = (state == IDLE) ? ar_legal : legal_q;
      cap_off   = cap_addr - BASE_ADDR;
      cap_data  = '0;
      cap_resp  = RESP_OKAY;
      if (!cap_legal)
         cap_resp = RESP_SLVERR;
      else if ((cap_addr < BASE_ADDR) || (cap_off >= (ADDR_WIDTH'(MEM_WORDS) << 3)))
         cap_resp = RESP_DECERR;
      else
         cap_data = mem[cap_off[3 +: IDX_W]];
   end

   always_ff @(posedge clk) begin
      if (load_we) mem[load_idx] <= load_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
         s_axi_rid     <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         size_q        <= '0;
         burst_q       <= '0;
         legal_q       <= 1'b0;
         beat_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               s_axi_arready <= 1'b1;
               if (ar_hs) begin
                  s_axi_rid     <= s_axi_arid;
                  addr_q        <= s_axi_araddr;
                  len_q         <= s_axi_arlen;
                  size_q        <= s_axi_arsize;
                  burst_q       <= s_axi_arburst;
                  legal_q       <= ar_legal;
                  beat_cnt      <= '0;
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rlast   <= (s_axi_arlen == 8'd0);
                  s_axi_rdata   <= cap_data;
                  s_axi_rresp   <= cap_resp;
                  state         <= BURST;
               end
            end
            BURST: begin
               if (r_hs) begin
                  if (s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     addr_q      <= next_addr;
                     beat_cnt    <= beat_cnt + 8'd1;
                     s_axi_rlast <= ((beat_cnt + 8'd1) == len_q);
                     s_axi_rdata <= cap_data;
                     s_axi_rresp <= cap_resp;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
